inv_key_expand: RTL and testbench
=================================

INV_KEY_EXPAND -- requirements
Module: inv_key_expand

Interface
REQ-001 SHALL have no parameters; AES-128 only, with 128-bit keys and 10 rounds.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request to begin a reverse key schedule; sampled only in IDLE.
REQ-005 last_key  input  [0:127]  round-10 key, bit 0 = MSB of word w40; sampled on accepted start.
REQ-006 key_ready  input  1  downstream can accept key_out this cycle.
REQ-007 key_valid  output  1  key_out/round_idx hold a valid round key.
REQ-008 key_out  output  [0:127]  current round key, big-endian word order w[4r..4r+3].
REQ-009 round_idx  output  [3:0]  round number of key_out, 10 down to 0.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 done  output  1  one-cycle pulse after the round-0 key handshake.

Function
REQ-012 SHALL implement FSM states IDLE and EMIT.
- IDLE -> EMIT on start=1, loading key register=last_key and round=10.
- EMIT -> IDLE on handshake (key_valid & key_ready) when round=0.
REQ-013 Reverse step from round r to r-1, with k0..k3 as the current words:
- p3=k3^k2; p2=k2^k1; p1=k1^k0.
- p0=k0^SubWord(RotWord(p3))^{Rcon[r],24'h0}.
REQ-014 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36; Rcon is indexed by the current round r, not r-1.
REQ-015 RotWord SHALL rotate the word left by one byte. SubWord SHALL apply the forward AES S-box to each byte.
REQ-016 On handshake with round>0, the key register SHALL take the previous-round key and round SHALL decrement, both on the same edge.
- key_valid stays high, giving throughput of one key per cycle under continuous key_ready.
REQ-017 With key_valid=1 and key_ready=0, key_out and round_idx SHALL hold stable.
REQ-018 First key_valid SHALL assert on the cycle after the start edge (latency 1) and carry round_idx=10.
REQ-019 start asserted while busy=1 SHALL be ignored, with no restart and no effect on the sequence.
REQ-020 done SHALL pulse exactly one cycle, concurrent with the return to IDLE; key_valid=0 in that cycle.
REQ-021 round SHALL never wrap below 0; no Rcon[0] access occurs.
REQ-022 start and key_ready arriving in the same cycle in IDLE: only start SHALL act, since key_valid=0.

Reset
REQ-023 On rst_n=0 at a clock edge, in any state including mid-sequence: state=IDLE, key_valid=0, done=0, busy=0, round_idx=0, key_out=0.
REQ-024 A sequence interrupted by reset SHALL NOT resume; a new start is required.

Configuration
REQ-025 Macro INV_KEY_EXPAND_STREAM_EN selects the output mode.
REQ-026 Defined: every round key 10..0 SHALL be emitted with a handshake, per REQ-016..018.
REQ-027 Undefined: round-10..1 keys SHALL be computed internally at one step per cycle with key_valid=0 and key_ready ignored.
- key_valid SHALL rise 10 cycles after the start edge, with round_idx=0.
- Only that final key is handshaken; done follows as in REQ-020.

Structure
REQ-028 Shared package aes_pkg SHALL hold the Rcon table, the AES-128 round count constant (10), and the 128-bit key and 32-bit word types.
REQ-029 SubWord SHALL be the existing subword module (four S-box instances), instantiated once. No other sub-module.
REQ-030 The datapath of REQ-013 SHALL be combinational from the key register; there is no extra pipeline stage.

Verification
REQ-031 FIPS-197 A.1 vector, with STREAM_EN defined and key_ready=1:
- Stimulus: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, then start.
- Response: round 10 key, then ac7766f319fadc2128d12941575c006e (round 9), ..., 2b7e151628aed2a6abf7158809cf4f3c (round 0).
- 11 consecutive valid cycles, then done.
REQ-032 Backpressure: hold key_ready=0 for 5 cycles at round_idx=7 -> key_out stable and valid held; the sequence resumes correctly on release.
REQ-033 Pulse start every cycle during a sequence -> no restart and no change in the round_idx order.
REQ-034 Assert rst_n=0 at round_idx=4 -> next cycle key_valid=0 and busy=0. A subsequent start reproduces the REQ-031 sequence in full.
REQ-035 STREAM_EN undefined, same vector -> key_valid first high 10 cycles after start, with key_out=2b7e151628aed2a6abf7158809cf4f3c and round_idx=0.
REQ-036 Last key all-zero -> round-0 key matches a software reverse-schedule model; done pulses exactly once.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the reverse key schedule.
// Rcon is stored as a 16-entry table so any 4-bit round value indexes it safely.
package aes_pkg;

    localparam logic [3:0] AES128_ROUNDS = 4'd10;

    typedef logic [0:127] key128_t;
    typedef logic [0:31]  word_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Entry r holds Rcon[r]; entries 0 and 11..15 are unused and read as zero.
    localparam logic [7:0] RCON_TBL [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/subword.sv
// SubWord: forward AES S-box applied to each of the four bytes of a word.
module subword
    import aes_pkg::*;
(
    input  word_t i_word,
    output word_t o_word
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign o_word[8*i +: 8] = SBOX[i_word[8*i +: 8]];
    end

endmodule

// File: rtl/inv_key_expand.sv
// AES-128 reverse key schedule: walks from the round-10 key back to the cipher key.
// Macro INV_KEY_EXPAND_STREAM_EN: defined = hand off every round key; undefined = only round 0.
module inv_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] last_key,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [0:127] key_out,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    // Handshake: a key transfers on any rising edge where key_valid & key_ready;
    // while key_valid is high and key_ready low, key_out/round_idx do not move.

    state_t     r_state, w_state_nxt;
    key128_t    r_key, w_key_nxt;
    logic [3:0] r_round, w_round_nxt;
    logic       r_done, w_done_nxt;

    word_t w_k0, w_k1, w_k2, w_k3;
    word_t w_p0, w_p1, w_p2, w_p3;
    word_t w_rot, w_sub;
    logic [7:0] w_rcon;
    logic w_valid, w_hs, w_step;

    assign w_k0 = r_key[0:31];
    assign w_k1 = r_key[32:63];
    assign w_k2 = r_key[64:95];
    assign w_k3 = r_key[96:127];

    // Previous-round words; p3 must be recovered first since p0 depends on it.
    assign w_p3 = w_k3 ^ w_k2;
    assign w_p2 = w_k2 ^ w_k1;
    assign w_p1 = w_k1 ^ w_k0;
    assign w_rot = {w_p3[8:31], w_p3[0:7]};

    subword u_subword (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_rcon = (r_round == 4'd0) ? 8'h00 : RCON_TBL[r_round];
    assign w_p0   = w_k0 ^ w_sub ^ {w_rcon, 24'h000000};

`ifdef INV_KEY_EXPAND_STREAM_EN
    assign w_valid = (r_state == ST_EMIT);
    assign w_step  = w_valid && key_ready && (r_round != 4'd0);
`else
    // Intermediate keys stay internal; only the round-0 key is offered.
    assign w_valid = (r_state == ST_EMIT) && (r_round == 4'd0);
    assign w_step  = (r_state == ST_EMIT) && (r_round != 4'd0);
`endif

    assign w_hs = w_valid && key_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_EMIT;
                    w_key_nxt   = last_key;
                    w_round_nxt = AES128_ROUNDS;
                end
            end
            ST_EMIT: begin
                if (w_step) begin
                    w_key_nxt   = {w_p0, w_p1, w_p2, w_p3};
                    w_round_nxt = r_round - 4'd1;
                end else if (w_hs) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_round <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_round <= w_round_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign key_valid = w_valid;
    assign key_out   = r_key;
    assign round_idx = r_round;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_inv_key_expand.sv
// Directed bench for inv_key_expand; follows INV_KEY_EXPAND_STREAM_EN like the RTL.
module tb_inv_key_expand;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] last_key;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int done_exp = 0;

    logic [127:0] exp_rk [0:10];

    inv_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .last_key  (last_key),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done) done_seen++;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- software reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        logic [7:0] s;
        r = 8'h01;
        base = a;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] sw_prev(input logic [127:0] k, input int r);
        logic [31:0] k0, k1, k2, k3, p0, p1, p2, p3, rot, sub;
        logic [7:0] rc;
        k0 = k[127:96];
        k1 = k[95:64];
        k2 = k[63:32];
        k3 = k[31:0];
        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        rot = {p3[23:0], p3[31:24]};
        for (int b = 0; b < 4; b++) sub[8*b +: 8] = sbox_calc(rot[8*b +: 8]);
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        p0 = k0 ^ sub ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    task automatic load_model(input logic [127:0] k10);
        exp_rk[10] = k10;
        for (int r = 10; r >= 1; r--) exp_rk[r-1] = sw_prev(exp_rk[r], r);
    endtask

    task automatic load_fips();
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_seq(input logic [127:0] key);
        @(posedge clk);
        #1;
        last_key  = key;
        start     = 1'b1;
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, key_valid, 1'b0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_done"},  done,      1'b0);
        check({tag, "_round"}, round_idx, 4'd0);
        check({tag, "_key"},   key_out,   128'h0);
    endtask

    task automatic reset_and_idle(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state(tag);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check({tag, "_noresume_busy"},  busy,      1'b0);
            check({tag, "_noresume_valid"}, key_valid, 1'b0);
        end
    endtask

    task automatic finish_checks(input string tag);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done"},       done,      1'b1);
        check({tag, "_done_valid"}, key_valid, 1'b0);
        check({tag, "_done_busy"},  busy,      1'b0);
        done_exp++;
        @(negedge clk);
        check({tag, "_done_once"},  done,      1'b0);
    endtask

    // abort_at: stream mode = round_idx at which reset hits; else cycles after start.
    task automatic run_seq(input string tag, input bit stall, input bit spam, input int abort_at);
        bit aborted;
        aborted = 1'b0;
        start_seq(exp_rk[10]);
`ifdef INV_KEY_EXPAND_STREAM_EN
        for (int r = 10; r >= 0; r--) begin
            @(negedge clk);
            check({tag, "_valid"}, key_valid, 1'b1);
            check({tag, "_round"}, round_idx, r[3:0]);
            check({tag, "_key"},   key_out,   exp_rk[r]);
            if (r == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (spam) start = (r != 0);
            if (stall && r == 7) begin
                key_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check({tag, "_hold_valid"}, key_valid, 1'b1);
                    check({tag, "_hold_round"}, round_idx, 4'd7);
                    check({tag, "_hold_key"},   key_out,   exp_rk[7]);
                end
                key_ready = 1'b1;
            end
        end
`else
        if (spam) start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check({tag, "_hidden_valid"}, key_valid, 1'b0);
            check({tag, "_hidden_busy"},  busy,      1'b1);
            if (c == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (stall && c == 9) key_ready = 1'b0;
        end
        if (!aborted) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, "_valid"}, key_valid, 1'b1);
            check({tag, "_round"}, round_idx, 4'd0);
            check({tag, "_key"},   key_out,   exp_rk[0]);
            if (stall) begin
                repeat (3) begin
                    @(negedge clk);
                    check({tag, "_hold_valid"}, key_valid, 1'b1);
                    check({tag, "_hold_key"},   key_out,   exp_rk[0]);
                end
                key_ready = 1'b1;
            end
        end
`endif
        start = 1'b0;
        if (aborted) reset_and_idle({tag, "_rst"});
        else finish_checks(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        last_key  = 128'h0;
        key_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("idle");

        load_fips();
        run_seq("fips", 1'b0, 1'b0, -1);
        run_seq("stall_spam", 1'b1, 1'b1, -1);
`ifdef INV_KEY_EXPAND_STREAM_EN
        run_seq("abort", 1'b0, 1'b0, 4);
`else
        run_seq("abort", 1'b0, 1'b0, 5);
`endif
        run_seq("after_rst", 1'b0, 1'b0, -1);

        load_model(128'h0);
        run_seq("zero", 1'b0, 1'b0, -1);

        load_model(128'h000102030405060708090a0b0c0d0e0f);
        run_seq("ramp", 1'b1, 1'b0, -1);

        repeat (2) @(negedge clk);
        check("done_pulses", done_seen, done_exp);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
